// File: rtl/dsp_seq_pkg.sv
// Shared definitions for the DSP host sequencer: FSM states and the
// single-byte protocol tokens exchanged with the host over UART_IF.
package dsp_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND_F,
    ST_WAIT_H,
    ST_SEND_A,
    ST_LOAD_COEF,
    ST_SEND_R,
    ST_LOAD_DATA,
    ST_SEND_I,
    ST_RUN_FIR,
    ST_RUN_FFT,
    ST_SEND_D
  } state_e;

  localparam logic [7:0] HS_REQ   = 8'h39;
  localparam logic [7:0] HS_ACK   = 8'h46;
  localparam logic [7:0] CF_REQ   = 8'h68;
  localparam logic [7:0] CF_ACK   = 8'h61;
  localparam logic [7:0] DT_ACK   = 8'h72;
  localparam logic [7:0] RUN_ACK  = 8'h69;
  localparam logic [7:0] DONE_ACK = 8'h44;

endpackage

// File: rtl/dsp_host_sequencer_packer.sv
// Assembles MSB-first byte pairs into 16-bit words and issues one write
// strobe per word, one cycle after the low byte, with a running word address.
module byte_word_packer #(
  parameter int AW = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic [7:0]    byte_i,
  input  logic [AW-1:0] last_idx_i,
  output logic          wen_o,
  output logic [AW-1:0] waddr_o,
  output logic [15:0]   wdata_o,
  output logic          last_o
);

  logic          phase_q;
  logic [7:0]    hi_q;
  logic [AW-1:0] cnt_q;
  logic          wen_q;
  logic          last_q;
  logic [AW-1:0] waddr_q;
  logic [15:0]   wdata_q;

  // Clear has priority so a discarded high byte never pairs with a later byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      last_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q  <= 1'b0;
      last_q <= 1'b0;
      if (clear_i) begin
        phase_q <= 1'b0;
        hi_q    <= '0;
        cnt_q   <= '0;
      end else if (valid_i) begin
        if (!phase_q) begin
          hi_q    <= byte_i;
          phase_q <= 1'b1;
        end else begin
          wen_q   <= 1'b1;
          wdata_q <= {hi_q, byte_i};
          waddr_q <= cnt_q;
          last_q  <= (cnt_q == last_idx_i);
          cnt_q   <= cnt_q + 1'b1;
          phase_q <= 1'b0;
        end
      end
    end
  end

  assign wen_o   = wen_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
  assign last_o  = wen_q & last_q;

endmodule

// File: rtl/dsp_host_sequencer.sv
// Host command sequencer: runs the UART byte handshake, loads coefficient and
// sample buffers, then starts FIR and FFT in turn and reports completion.
module dsp_host_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int NCOEF   = 64,
  parameter int NSAMP   = 1024,
  parameter int TIMEOUT = 65535
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [7:0]               RX_DATA,
  input  logic                     RX_VALID,
  output logic [7:0]               TX_DATA,
  output logic                     TX_VALID,
  input  logic                     TX_READY,
  output logic                     COEF_WEN,
  output logic [$clog2(NCOEF)-1:0] COEF_WADDR,
  output logic [15:0]              COEF_WDATA,
  output logic                     DIN_WEN,
  output logic [$clog2(NSAMP)-1:0] DIN_WADDR,
  output logic [15:0]              DIN_WDATA,
  output logic                     FIR_START,
  input  logic                     FIR_DONE,
  output logic                     FFT_START,
  input  logic                     FFT_DONE,
  output logic                     BUSY,
  output logic                     ERR
);

  localparam int CW = $clog2(NCOEF);
  localparam int SW = $clog2(NSAMP);
  localparam int AW = (CW > SW) ? CW : SW;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          fir_start_q, fft_start_q;
  logic          in_load, entering_load, timeout_hit;
  logic          pk_wen, pk_last;
  logic [AW-1:0] pk_addr, last_idx;
  logic [15:0]   pk_data;

  assign in_load       = (state_q == ST_LOAD_COEF) || (state_q == ST_LOAD_DATA);
  assign entering_load = ((state_d == ST_LOAD_COEF) || (state_d == ST_LOAD_DATA)) &&
                         (state_d != state_q);
  // A byte arriving on the expiry cycle wins over the abort.
  assign timeout_hit   = in_load && !RX_VALID && (tmo_q == TW'(TIMEOUT - 1));
  assign last_idx      = (state_q == ST_LOAD_COEF) ? AW'(NCOEF - 1) : AW'(NSAMP - 1);

  byte_word_packer #(.AW(AW)) u_packer (
    .clk_i      (CLK),
    .rst_ni     (RESET_N),
    .clear_i    (timeout_hit | entering_load),
    .valid_i    (RX_VALID & in_load),
    .byte_i     (RX_DATA),
    .last_idx_i (last_idx),
    .wen_o      (pk_wen),
    .waddr_o    (pk_addr),
    .wdata_o    (pk_data),
    .last_o     (pk_last)
  );

  always_comb begin
    state_d  = state_q;
    TX_VALID = 1'b0;
    TX_DATA  = 8'h00;
    case (state_q)
      ST_IDLE:      if (RX_VALID && RX_DATA == HS_REQ) state_d = ST_SEND_F;
      ST_SEND_F: begin
        TX_VALID = 1'b1;
        TX_DATA  = HS_ACK;
        if (TX_READY) state_d = ST_WAIT_H;
      end
      ST_WAIT_H:    if (RX_VALID && RX_DATA == CF_REQ) state_d = ST_SEND_A;
      ST_SEND_A: begin
        TX_VALID = 1'b1;
        TX_DATA  = CF_ACK;
        if (TX_READY) state_d = ST_LOAD_COEF;
      end
      ST_LOAD_COEF: begin
        if (timeout_hit)  state_d = ST_IDLE;
        else if (pk_last) state_d = ST_SEND_R;
      end
      ST_SEND_R: begin
        TX_VALID = 1'b1;
        TX_DATA  = DT_ACK;
        if (TX_READY) state_d = ST_LOAD_DATA;
      end
      ST_LOAD_DATA: begin
        if (timeout_hit)  state_d = ST_IDLE;
        else if (pk_last) state_d = ST_SEND_I;
      end
      ST_SEND_I: begin
        TX_VALID = 1'b1;
        TX_DATA  = RUN_ACK;
        if (TX_READY) state_d = ST_RUN_FIR;
      end
      // Done inputs are ignored during the start cycle itself.
      ST_RUN_FIR:   if (!fir_start_q && FIR_DONE) state_d = ST_RUN_FFT;
      ST_RUN_FFT:   if (!fft_start_q && FFT_DONE) state_d = ST_SEND_D;
      ST_SEND_D: begin
        TX_VALID = 1'b1;
        TX_DATA  = DONE_ACK;
        if (TX_READY) state_d = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (!in_load || RX_VALID || state_d != state_q) tmo_d = '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      fir_start_q <= 1'b0;
      fft_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      fir_start_q <= (state_d == ST_RUN_FIR) && (state_q != ST_RUN_FIR);
      fft_start_q <= (state_d == ST_RUN_FFT) && (state_q != ST_RUN_FFT);
    end
  end

  assign COEF_WEN   = pk_wen && (state_q == ST_LOAD_COEF);
  assign COEF_WADDR = CW'(pk_addr);
  assign COEF_WDATA = pk_data;
  assign DIN_WEN    = pk_wen && (state_q == ST_LOAD_DATA);
  assign DIN_WADDR  = SW'(pk_addr);
  assign DIN_WDATA  = pk_data;
  assign FIR_START  = fir_start_q;
  assign FFT_START  = fft_start_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign ERR        = timeout_hit;

endmodule

// File: tb/tb_dsp_host_sequencer.sv
// Directed bench for dsp_host_sequencer with NCOEF=4, NSAMP=8, TIMEOUT=50.
// Inputs change 2 time units after the rising edge; outputs are read there or at the falling edge.
module tb_dsp_host_sequencer;

  logic        CLK, RESET_N;
  logic [7:0]  RX_DATA, TX_DATA;
  logic        RX_VALID, TX_VALID, TX_READY;
  logic        COEF_WEN, DIN_WEN;
  logic [1:0]  COEF_WADDR;
  logic [2:0]  DIN_WADDR;
  logic [15:0] COEF_WDATA, DIN_WDATA;
  logic        FIR_START, FIR_DONE, FFT_START, FFT_DONE, BUSY, ERR;

  int checks = 0;
  int errors = 0;
  logic [7:0] txLog[$];
  int coefWrCnt, dinWrCnt, firStartCnt, fftStartCnt, errCnt;

  logic [7:0]  coefBytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [15:0] expCoef   [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  logic [7:0]  expTx     [5] = '{8'h46, 8'h61, 8'h72, 8'h69, 8'h44};

  dsp_host_sequencer #(.NCOEF(4), .NSAMP(8), .TIMEOUT(50)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .COEF_WEN(COEF_WEN), .COEF_WADDR(COEF_WADDR), .COEF_WDATA(COEF_WDATA),
    .DIN_WEN(DIN_WEN), .DIN_WADDR(DIN_WADDR), .DIN_WDATA(DIN_WDATA),
    .FIR_START(FIR_START), .FIR_DONE(FIR_DONE), .FFT_START(FFT_START),
    .FFT_DONE(FFT_DONE), .BUSY(BUSY), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RESET_N) begin
      if (TX_VALID && TX_READY) txLog.push_back(TX_DATA);
      if (COEF_WEN)  coefWrCnt++;
      if (DIN_WEN)   dinWrCnt++;
      if (FIR_START) firStartCnt++;
      if (FFT_START) fftStartCnt++;
      if (ERR)       errCnt++;
    end
  end

  function automatic logic [51:0] allOutputs();
    return {TX_VALID, TX_DATA, COEF_WEN, COEF_WADDR, COEF_WDATA, DIN_WEN,
            DIN_WADDR, DIN_WDATA, FIR_START, FFT_START, BUSY, ERR};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    tick(1);
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
  endtask

  task automatic clearLogs();
    txLog.delete();
    coefWrCnt = 0; dinWrCnt = 0; firStartCnt = 0; fftStartCnt = 0; errCnt = 0;
  endtask

  task automatic doReset();
    RESET_N  = 1'b0;
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
    TX_READY = 1'b1;
    FIR_DONE = 1'b0;
    FFT_DONE = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tick(1);
    clearLogs();
  endtask

  task automatic handshake();
    sendByte(8'h39);
    tick(2);
    sendByte(8'h68);
    tick(2);
  endtask

  task automatic loadCoefs();
    for (int i = 0; i < 8; i++) sendByte(coefBytes[i]);
    tick(2);
  endtask

  task automatic loadData();
    for (int i = 0; i < 8; i++) begin
      sendByte(8'hA0 + 8'(i));
      sendByte(8'h10 + 8'(i));
    end
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (allOutputs() !== 52'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", allOutputs());
    end
  endtask

  task automatic test_nominal();
    doReset();
    handshake();
    for (int i = 0; i < 4; i++) begin
      sendByte(coefBytes[2*i]);
      sendByte(coefBytes[2*i+1]);
      checks++;
      if ({COEF_WEN, DIN_WEN, COEF_WADDR, COEF_WDATA} !== {1'b1, 1'b0, 2'(i), expCoef[i]}) begin
        errors++;
        $display("[TB] FAIL coef_write[%0d]: got wen=%b din=%b a=%0d d=%h expected 1 0 %0d %h",
                 i, COEF_WEN, DIN_WEN, COEF_WADDR, COEF_WDATA, i, expCoef[i]);
      end
    end
    tick(2);
    for (int i = 0; i < 8; i++) begin
      sendByte(8'hA0 + 8'(i));
      sendByte(8'h10 + 8'(i));
      checks++;
      if ({DIN_WEN, COEF_WEN, DIN_WADDR, DIN_WDATA} !== {1'b1, 1'b0, 3'(i), 16'hA010 + 16'(i) * 16'h0101}) begin
        errors++;
        $display("[TB] FAIL din_write[%0d]: got wen=%b coef=%b a=%0d d=%h expected 1 0 %0d %h",
                 i, DIN_WEN, COEF_WEN, DIN_WADDR, DIN_WDATA, i, 16'hA010 + 16'(i) * 16'h0101);
      end
    end
    tick(1);
    checks++;
    if ({TX_VALID, TX_DATA} !== {1'b1, 8'h69}) begin
      errors++;
      $display("[TB] FAIL send_i: got v=%b d=%h expected 1 69", TX_VALID, TX_DATA);
    end
    tick(1);
    checks++;
    if ({FIR_START, FFT_START} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL fir_start: got %b expected 10", {FIR_START, FFT_START});
    end
    tick(18);
    FIR_DONE = 1'b1;
    tick(1);
    FIR_DONE = 1'b0;
    checks++;
    if ({FIR_START, FFT_START} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL fft_start: got %b expected 01", {FIR_START, FFT_START});
    end
    tick(5);
    FFT_DONE = 1'b1;
    tick(1);
    FFT_DONE = 1'b0;
    checks++;
    if ({TX_VALID, TX_DATA, BUSY} !== {1'b1, 8'h44, 1'b1}) begin
      errors++;
      $display("[TB] FAIL send_d: got v=%b d=%h busy=%b expected 1 44 1", TX_VALID, TX_DATA, BUSY);
    end
    tick(1);
    checks++;
    if ({BUSY, TX_VALID} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL nominal_idle: got busy=%b v=%b expected 0 0", BUSY, TX_VALID);
    end
    checks++;
    if (txLog.size() != 5 || txLog[0] !== expTx[0] || txLog[1] !== expTx[1] ||
        txLog[2] !== expTx[2] || txLog[3] !== expTx[3] || txLog[4] !== expTx[4]) begin
      errors++;
      $display("[TB] FAIL tx_sequence: got %0d bytes %p expected 46 61 72 69 44", txLog.size(), txLog);
    end
    checks++;
    if (coefWrCnt != 4 || dinWrCnt != 8 || firStartCnt != 1 || fftStartCnt != 1 || errCnt != 0) begin
      errors++;
      $display("[TB] FAIL nominal_counts: got coef=%0d din=%0d fir=%0d fft=%0d err=%0d expected 4 8 1 1 0",
               coefWrCnt, dinWrCnt, firStartCnt, fftStartCnt, errCnt);
    end
  endtask

  task automatic test_wrong_handshake();
    doReset();
    sendByte(8'h41);
    tick(2);
    sendByte(8'h68);
    tick(3);
    checks++;
    if (txLog.size() != 0 || BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrong_hs_ignored: got tx=%0d busy=%b expected 0 0", txLog.size(), BUSY);
    end
    sendByte(8'h39);
    checks++;
    if ({TX_VALID, TX_DATA} !== {1'b1, 8'h46}) begin
      errors++;
      $display("[TB] FAIL hs_ack: got v=%b d=%h expected 1 46", TX_VALID, TX_DATA);
    end
  endtask

  task automatic test_backpressure();
    int held = 0;
    doReset();
    TX_READY = 1'b0;
    sendByte(8'h39);
    for (int i = 0; i < 10; i++) begin
      if (TX_VALID === 1'b1 && TX_DATA === 8'h46) held++;
      tick(1);
    end
    checks++;
    if (held != 10) begin
      errors++;
      $display("[TB] FAIL bp_hold: got %0d held cycles expected 10", held);
    end
    TX_READY = 1'b1;
    tick(4);
    checks++;
    if (txLog.size() != 1 || TX_VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_single_transfer: got %0d transfers v=%b expected 1 0", txLog.size(), TX_VALID);
    end
  endtask

  task automatic test_timeout();
    doReset();
    handshake();
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
    tick(48);
    checks++;
    if (ERR !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_early: got err=%b expected 0", ERR);
    end
    tick(1);
    checks++;
    if ({ERR, BUSY} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL timeout_err: got err=%b busy=%b expected 1 1", ERR, BUSY);
    end
    tick(1);
    checks++;
    if ({ERR, BUSY} !== 2'b00 || errCnt != 1 || coefWrCnt != 1) begin
      errors++;
      $display("[TB] FAIL timeout_abort: got err=%b busy=%b errs=%0d writes=%0d expected 0 0 1 1",
               ERR, BUSY, errCnt, coefWrCnt);
    end
    handshake();
    sendByte(8'hAB);
    sendByte(8'hCD);
    checks++;
    if ({COEF_WEN, COEF_WADDR, COEF_WDATA} !== {1'b1, 2'd0, 16'hABCD}) begin
      errors++;
      $display("[TB] FAIL timeout_restart: got wen=%b a=%0d d=%h expected 1 0 abcd",
               COEF_WEN, COEF_WADDR, COEF_WDATA);
    end
  endtask

  task automatic test_early_fir_done();
    doReset();
    handshake();
    loadCoefs();
    FIR_DONE = 1'b1;
    loadData();
    tick(2);
    checks++;
    if ({FIR_START, FFT_START} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL early_done_start: got %b expected 10", {FIR_START, FFT_START});
    end
    tick(1);
    checks++;
    if ({FIR_START, FFT_START} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL early_done_sample: got %b expected 00", {FIR_START, FFT_START});
    end
    tick(1);
    FIR_DONE = 1'b0;
    checks++;
    if ({FIR_START, FFT_START} !== 2'b01 || firStartCnt != 1) begin
      errors++;
      $display("[TB] FAIL early_done_fft: got %b firs=%0d expected 01 1", {FIR_START, FFT_START}, firStartCnt);
    end
  endtask

  task automatic test_reset_mid_load();
    doReset();
    handshake();
    loadCoefs();
    sendByte(8'h55);
    sendByte(8'h66);
    #1;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (allOutputs() !== 52'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected 0", allOutputs());
    end
    tick(2);
    RESET_N = 1'b1;
    tick(1);
    clearLogs();
    loadData();
    tick(2);
    checks++;
    if (dinWrCnt != 0 || BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_no_write: got writes=%0d busy=%b expected 0 0", dinWrCnt, BUSY);
    end
    handshake();
    loadCoefs();
    sendByte(8'h77);
    sendByte(8'h88);
    checks++;
    if ({DIN_WEN, DIN_WADDR, DIN_WDATA} !== {1'b1, 3'd0, 16'h7788}) begin
      errors++;
      $display("[TB] FAIL post_reset_load: got wen=%b a=%0d d=%h expected 1 0 7788",
               DIN_WEN, DIN_WADDR, DIN_WDATA);
    end
  endtask

  initial begin
    RESET_N  = 1'b0;
    RX_DATA  = 8'h00;
    RX_VALID = 1'b0;
    TX_READY = 1'b1;
    FIR_DONE = 1'b0;
    FFT_DONE = 1'b0;
    clearLogs();
    test_reset();
    test_nominal();
    test_wrong_handshake();
    test_backpressure();
    test_timeout();
    test_early_fir_done();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_host_sequencer.md
Name: dsp_host_sequencer

Overview:
- Host-side command sequencer for the DSP flow demo; sits between UART_IF byte interface and the coefficient buffer, FIR input buffer, FIR control and FFT.
- Runs the byte handshake protocol: '9'/'F', 'h'/'a', coefficient load, 'r', sample load, 'i'.
- Packs bytes into 16-bit words, MSB first, and writes them to the buffers; then starts FIR, waits, starts FFT, waits, reports done.
- Replaces ad-hoc host sequencing with one synthesizable controller.

Parameters:
- NCOEF, 64, number of 16-bit coefficients loaded per run.
- NSAMP, 1024, number of 16-bit input samples loaded per run.
- TIMEOUT, 65535, max idle cycles between bytes during a load before abort.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- RX_DATA  in  8  received byte from UART_IF.
- RX_VALID  in  1  one-cycle pulse; RX_DATA is valid.
- TX_DATA  out  8  byte to transmit.
- TX_VALID  out  1  transmit request; held until accepted.
- TX_READY  in  1  UART_IF can accept a byte; transfer occurs when TX_VALID && TX_READY.
- COEF_WEN  out  1  coefficient buffer write strobe.
- COEF_WADDR  out  clog2(NCOEF)  coefficient address.
- COEF_WDATA  out  16  coefficient word.
- DIN_WEN  out  1  FIR input buffer write strobe.
- DIN_WADDR  out  clog2(NSAMP)  sample address.
- DIN_WDATA  out  16  sample word.
- FIR_START  out  1  one-cycle start pulse to FIR control.
- FIR_DONE  in  1  FILTER_COMPLETE from FIR control (level or pulse).
- FFT_START  out  1  one-cycle start pulse to FFT.
- FFT_DONE  in  1  FFT output complete.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: all outputs 0, state IDLE, byte/word counters 0, high-byte register 0. Reset mid-run aborts immediately; no partial writes complete.
- States and transitions:
  - IDLE: RX 0x39 -> SEND_F. Other bytes are ignored.
  - SEND_F: TX_DATA=0x46. On transfer -> WAIT_H.
  - WAIT_H: RX 0x68 -> SEND_A. Other bytes are ignored.
  - SEND_A: TX_DATA=0x61. On transfer -> LOAD_COEF.
  - LOAD_COEF: even byte -> high-byte register. Odd byte -> COEF_WEN=1 the next cycle with WDATA={hi,byte} and WADDR=word count.
    - After word NCOEF-1 is written -> SEND_R.
  - SEND_R: TX_DATA=0x72. On transfer -> LOAD_DATA.
  - LOAD_DATA: same packing on DIN_*. After word NSAMP-1 -> SEND_I.
  - SEND_I: TX_DATA=0x69. On transfer -> RUN_FIR, with FIR_START pulsed in the first cycle of RUN_FIR.
  - RUN_FIR: wait for FIR_DONE=1 -> RUN_FFT, with FFT_START pulsed in the first cycle of RUN_FFT.
  - RUN_FFT: wait for FFT_DONE=1 -> SEND_D.
  - SEND_D: TX_DATA=0x44 ('D'). On transfer -> IDLE.
- Write latency: strobe exactly 1 cycle after the low-byte RX_VALID; strobe width 1 cycle. Address counters never wrap within a load and reset to 0 on entering each load state.
- TX: TX_VALID rises on state entry; TX_DATA is stable while TX_VALID=1. Exactly one byte is sent per SEND_* state.
- RX_VALID in SEND_*, RUN_* states: byte dropped, no state change.
- FIR_DONE/FFT_DONE asserted before the corresponding start is issued: ignored. Sample only in RUN_FIR/RUN_FFT, starting the cycle after the start pulse.
- Timeout:
  - Scope: LOAD_* only. The counter clears on each RX_VALID and on entry.
  - Action: reaching TIMEOUT -> ERR pulse, go to IDLE, discard any pending high byte.
- RX_VALID on the same cycle the timeout is reached: the byte wins and the counter clears.

Decomposition:
- Shared package dsp_seq_pkg holds:
  - the state enum;
  - the protocol byte constants HS_REQ=0x39, HS_ACK=0x46, CF_REQ=0x68, CF_ACK=0x61, DT_ACK=0x72, RUN_ACK=0x69, DONE_ACK=0x44.
- One sub-module, byte_word_packer: high/low byte assembly, word counter, write strobe and terminal-count flag.
  - Instantiated once; its address and strobe are muxed to COEF_* or DIN_* by state.

Test Plan:
- Nominal run, NCOEF=4 and NSAMP=8:
  - Send 39 68, then 8 coefficient bytes 12 34 .. -> TX 46, 61.
  - COEF writes 0x1234.. at addresses 0..3 -> TX 72.
  - 16 data bytes -> DIN 0..7 written -> TX 69.
  - FIR_START pulse; FIR_DONE after 20 cycles -> FFT_START; FFT_DONE -> TX 44, BUSY=0.
- Wrong handshake bytes: in IDLE send 0x41, 0x68 -> no TX, state IDLE. Then 0x39 -> TX 0x46.
- Backpressure: TX_READY=0 for 10 cycles in SEND_F -> TX_VALID and TX_DATA=0x46 held. Exactly one transfer after READY rises.
- Timeout: TIMEOUT=50, stop after 3 coefficient bytes -> one COEF write only, ERR pulse at 50 idle cycles, BUSY=0. Next run starts cleanly at address 0.
- Early FIR_DONE held high during LOAD_DATA -> no FIR_START skipped. FFT_START is issued one cycle after RUN_FIR samples FIR_DONE.
- RESET_N low mid LOAD_DATA -> all outputs 0 asynchronously. After release, no DIN_WEN until a full new handshake.
